// File: rtl/invert_ios_pkg.sv
// Shared definitions for the inverted-IO micro-benchmark link.
// The inverter bench uses these too: 13-bit payload, plus a constant-1 marker bit on top.
package invert_ios_pkg;

    localparam int DATA_W     = 13;
    localparam int BUS_W      = DATA_W + 1;
    localparam int MARKER_BIT = DATA_W;

    typedef logic [DATA_W-1:0] io_word_t;
    typedef logic [BUS_W-1:0]  io_bus_t;

    // Undo the far-end inversion on the payload field.
    function automatic io_word_t restore_word(input io_bus_t bus);
        return ~bus[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/invert_ios_fifo.sv
// Small synchronous FIFO with first-word fall-through on the head entry.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module invert_ios_fifo #(
    parameter  int WIDTH = 13,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             pop_ok;
    logic             push_ok;

    assign wr_idx  = wr_ptr_reg[AW-1:0];
    assign rd_idx  = rd_ptr_reg[AW-1:0];
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    // Extra pointer bit separates "full" from "empty" when the indices match.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= push_data;
                wr_ptr_reg  <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/invert_ios_decoder.sv
// Receive end of the inverted-IO link: capture, marker check, restore, buffer.
// Saturating good/bad word counters and sticky flags report link health.
module invert_ios_decoder
    import invert_ios_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  io_bus_t          bus_in,
    input  logic             sample_en,
    input  logic             clear,
    output io_word_t         out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             marker_err,
    output logic             overflow
);

    io_bus_t          cap_reg;
    logic             cap_vld_reg;
    logic [CNT_W-1:0] word_count_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic             marker_err_reg;
    logic             overflow_reg;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic good_word;
    logic bad_word;
    logic dropped;

    assign good_word = cap_vld_reg && cap_reg[MARKER_BIT];
    assign bad_word  = cap_vld_reg && !cap_reg[MARKER_BIT];
    assign pop       = out_ready && !fifo_empty;
    // A good word is lost only when the FIFO is full and nothing leaves this cycle.
    assign dropped   = good_word && fifo_full && !pop;

    invert_ios_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (good_word),
        .push_data (restore_word(cap_reg)),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_reg        <= '0;
            cap_vld_reg    <= 1'b0;
            word_count_reg <= '0;
            err_count_reg  <= '0;
            marker_err_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            cap_vld_reg <= sample_en;
            if (sample_en) begin
                cap_reg <= bus_in;
            end
            if (clear) begin
                word_count_reg <= '0;
                err_count_reg  <= '0;
                marker_err_reg <= 1'b0;
                overflow_reg   <= 1'b0;
            end else begin
                if (good_word && !dropped && word_count_reg != '1) begin
                    word_count_reg <= word_count_reg + CNT_W'(1);
                end
                if (bad_word) begin
                    marker_err_reg <= 1'b1;
                    if (err_count_reg != '1) begin
                        err_count_reg <= err_count_reg + CNT_W'(1);
                    end
                end
                if (dropped) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = !fifo_empty;
    assign word_count = word_count_reg;
    assign err_count  = err_count_reg;
    assign marker_err = marker_err_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_invert_ios_decoder.sv
// Directed bench for invert_ios_decoder: a default instance plus a 4-bit-counter one.
module tb_invert_ios_decoder;
    import invert_ios_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     sample_en;
    logic     clear;
    logic     out_ready;
    io_bus_t  bus_in;

    io_word_t    out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic        marker_err;
    logic        overflow;

    io_word_t    sat_out_data;
    logic        sat_out_valid;
    logic [2:0]  sat_fifo_level;
    logic [3:0]  sat_word_count;
    logic [3:0]  sat_err_count;
    logic        sat_marker_err;
    logic        sat_overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    invert_ios_decoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .sample_en(sample_en), .clear(clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .word_count(word_count), .err_count(err_count),
        .marker_err(marker_err), .overflow(overflow)
    );

    invert_ios_decoder #(.FIFO_DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .sample_en(sample_en), .clear(clear),
        .out_data(sat_out_data), .out_valid(sat_out_valid), .out_ready(out_ready),
        .fifo_level(sat_fifo_level), .word_count(sat_word_count), .err_count(sat_err_count),
        .marker_err(sat_marker_err), .overflow(sat_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; out_ready = 1'b0; bus_in = '0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else pass_cnt++;
        total_cnt++; if (out_data !== 13'h0) $display("FAIL reset_data got=%h exp=0", out_data); else pass_cnt++;
        total_cnt++; if ({word_count, err_count} !== 32'h0) $display("FAIL reset_counts got=%h exp=0", {word_count, err_count}); else pass_cnt++;
        total_cnt++; if ({marker_err, overflow} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {marker_err, overflow}); else pass_cnt++;
        step(); step();
        rst_n = 1'b1;
        step();
        $display("tx reset released");
    endtask

    task automatic test_good_word();
        out_ready = 1'b1; bus_in = 14'h2543; sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL good_early_valid got=%0b exp=0", out_valid); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL good_valid got=%0b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 13'h1ABC) $display("FAIL good_data got=%h exp=1abc", out_data); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd1) $display("FAIL good_word_count got=%0d exp=1", word_count); else pass_cnt++;
        $display("tx good word bus=2543 data=%h", out_data);
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL good_popped got=%0b exp=0", out_valid); else pass_cnt++;
        step();
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL empty_pop_level got=%0d exp=0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_zero_payload();
        bus_in = 14'h3FFF; sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL zero_valid got=%0b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 13'h0000) $display("FAIL zero_data got=%h exp=0000", out_data); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd0) $display("FAIL zero_err_count got=%0d exp=0", err_count); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd2) $display("FAIL zero_word_count got=%0d exp=2", word_count); else pass_cnt++;
        $display("tx zero payload bus=3fff data=%h", out_data);
        step();
    endtask

    task automatic test_bad_marker();
        bus_in = 14'h0543; sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bad_valid got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd1) $display("FAIL bad_err_count got=%0d exp=1", err_count); else pass_cnt++;
        total_cnt++; if (marker_err !== 1'b1) $display("FAIL bad_marker_err got=%0b exp=1", marker_err); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd2) $display("FAIL bad_word_count got=%0d exp=2", word_count); else pass_cnt++;
        $display("tx bad marker bus=0543 err_count=%0d", err_count);
        pulse_clear();
        total_cnt++; if (err_count !== 16'd0) $display("FAIL clear_err_count got=%0d exp=0", err_count); else pass_cnt++;
        total_cnt++; if (marker_err !== 1'b0) $display("FAIL clear_marker_err got=%0b exp=0", marker_err); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd0) $display("FAIL clear_word_count got=%0d exp=0", word_count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        io_word_t p [5];
        p = '{13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF, 13'h0123};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_in = {1'b1, ~p[i]}; sample_en = 1'b1;
            step();
        end
        sample_en = 1'b0;
        step();
        total_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", fifo_level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd4) $display("FAIL ovf_word_count got=%0d exp=4", word_count); else pass_cnt++;
        step();
        total_cnt++; if (out_data !== p[0]) $display("FAIL ovf_head_stable got=%h exp=%h", out_data, p[0]); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (out_data !== p[i]) $display("FAIL ovf_drain_%0d got=%h exp=%h", i, out_data, p[i]); else pass_cnt++;
            $display("tx drain %0d data=%h", i, out_data);
            step();
        end
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf_drained got=%0b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        io_word_t exp_head;
        pulse_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_in = {1'b1, ~(13'h0100 + 13'(k))}; sample_en = 1'b1;
            step();
        end
        total_cnt++; if (fifo_level !== 3'd4) $display("FAIL fpp_fill_level got=%0d exp=4", fifo_level); else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 5; k < 11; k++) begin
            exp_head = 13'h0100 + 13'(k - 5);
            total_cnt++; if (out_data !== exp_head) $display("FAIL fpp_head_%0d got=%h exp=%h", k, out_data, exp_head); else pass_cnt++;
            bus_in = {1'b1, ~(13'h0100 + 13'(k))};
            step();
            total_cnt++; if (fifo_level !== 3'd4) $display("FAIL fpp_level_%0d got=%0d exp=4", k, fifo_level); else pass_cnt++;
            total_cnt++; if (overflow !== 1'b0) $display("FAIL fpp_overflow_%0d got=%0b exp=0", k, overflow); else pass_cnt++;
            $display("tx push+pop %0d level=%0d", k, fifo_level);
        end
        sample_en = 1'b0;
        total_cnt++; if (word_count !== 16'd10) $display("FAIL fpp_word_count got=%0d exp=10", word_count); else pass_cnt++;
        for (int k = 0; k < 6; k++) step();
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL fpp_drained got=%0d exp=0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_saturation_reset();
        pulse_clear();
        out_ready = 1'b0;
        bus_in = {1'b1, ~13'h0777}; sample_en = 1'b1;
        step();
        bus_in = 14'h0543;
        for (int i = 0; i < 20; i++) step();
        sample_en = 1'b0;
        step();
        total_cnt++; if (sat_err_count !== 4'd15) $display("FAIL sat_err_count got=%0d exp=15", sat_err_count); else pass_cnt++;
        total_cnt++; if (err_count !== 16'd20) $display("FAIL wide_err_count got=%0d exp=20", err_count); else pass_cnt++;
        total_cnt++; if (sat_marker_err !== 1'b1) $display("FAIL sat_marker_err got=%0b exp=1", sat_marker_err); else pass_cnt++;
        total_cnt++; if (sat_word_count !== 4'd1) $display("FAIL sat_word_count got=%0d exp=1", sat_word_count); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 13'h0777) $display("FAIL sat_head got=%b/%h exp=1/0777", out_valid, out_data); else pass_cnt++;
        $display("tx saturation err_count=%0d wide=%0d", sat_err_count, err_count);
        sample_en = 1'b1;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({out_valid, fifo_level, out_data} !== 17'h0) $display("FAIL async_fifo got=%h exp=0", {out_valid, fifo_level, out_data}); else pass_cnt++;
        total_cnt++; if ({word_count, err_count, marker_err, overflow} !== 34'h0) $display("FAIL async_status got=%h exp=0", {word_count, err_count, marker_err, overflow}); else pass_cnt++;
        total_cnt++; if ({sat_out_valid, sat_fifo_level, sat_word_count, sat_err_count, sat_marker_err, sat_overflow} !== 14'h0) $display("FAIL async_sat got=%h exp=0", {sat_out_valid, sat_fifo_level, sat_word_count, sat_err_count, sat_marker_err, sat_overflow}); else pass_cnt++;
        total_cnt++; if (sat_out_data !== 13'h0) $display("FAIL async_sat_data got=%h exp=0", sat_out_data); else pass_cnt++;
        $display("tx async reset asserted mid-burst");
        sample_en = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        total_cnt++; if (out_valid !== 1'b0 || word_count !== 16'd0) $display("FAIL post_reset got=%b/%0d exp=0/0", out_valid, word_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_word();
        test_zero_payload();
        test_bad_marker();
        test_overflow();
        test_full_push_pop();
        test_saturation_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
